// File: rtl/riot_port_conditioner.sv
// rtl/riot_port_conditioner.sv - synchronise, debounce, SOCD-filter and pause-stretch raw RIOT port levels
// All levels are active-low; outputs feed RIOT PA_in/PB_in directly.
module riot_port_conditioner #(
  parameter int               DEB_W       = 16,
  parameter logic [DEB_W-1:0] DEB_CYC     = 16'd512,
  parameter logic [DEB_W-1:0] PAUSE_HOLD  = 16'd8000,
  parameter bit               SOCD_FILTER = 1'b1
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       ce,
  input  logic [7:0] pa_raw,
  input  logic [7:0] pb_raw,
  output logic [7:0] pa_in,
  output logic [7:0] pb_in,
  output logic       in_change
);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} pause_state_t;

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_CYC - DEB_W'(1);
  localparam logic [DEB_W-1:0] HOLD_LAST = PAUSE_HOLD - DEB_W'(1);

  logic [15:0]      raw, sync1, sync2, stable;
  logic [DEB_W-1:0] cnt [16];

  pause_state_t     state, state_nxt;
  logic [DEB_W-1:0] hold_cnt, hold_nxt;
  logic             p_prev, pause_out;
  logic [7:0]       pa_f, pb_f;

  assign raw = {pb_raw, pa_raw};

  // Synchronisers run every clk so async edges are captured even while ce is low.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      stable <= '1;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else if (ce) begin
      for (int i = 0; i < 16; i++) begin
        if (DEB_CYC == '0) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else if (cnt[i] != {DEB_W{1'b1}}) begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Nibble order per stick is R,L,D,U; an impossible opposing pair reads as released.
  function automatic logic [3:0] socd(input logic [3:0] s);
    logic [3:0] o;
    o = s;
    if (SOCD_FILTER) begin
      if (s[3:2] == 2'b00) o[3:2] = 2'b11;
      if (s[1:0] == 2'b00) o[1:0] = 2'b11;
    end
    return o;
  endfunction

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      p_prev   <= 1'b1;
    end else if (ce) begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      p_prev   <= stable[11];
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    pause_out = stable[11];
    case (state)
      IDLE: begin
        if (!stable[11] && p_prev && PAUSE_HOLD != '0) begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_LAST;
        end
      end
      HOLD: begin
        pause_out = 1'b0;
        if (hold_cnt == '0) state_nxt = stable[11] ? IDLE : WAIT_REL;
        else                hold_nxt  = hold_cnt - DEB_W'(1);
      end
      WAIT_REL: begin
        if (stable[11]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pa_f = {socd(stable[7:4]), socd(stable[3:0])};
  assign pb_f = {stable[15:12], pause_out, stable[10:8]};

  always_ff @(posedge clk) begin
    if (!res_n) begin
      pa_in     <= 8'hFF;
      pb_in     <= 8'hFF;
      in_change <= 1'b0;
    end else if (ce) begin
      pa_in     <= pa_f;
      pb_in     <= pb_f;
      in_change <= ({pa_f, pb_f} != {pa_in, pb_in});
    end else begin
      in_change <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riot_port_conditioner.sv
// tb/tb_riot_port_conditioner.sv - bench for riot_port_conditioner
// Directed scenarios plus randomized traffic against a tick-level behavioural model.
module tb_riot_port_conditioner;

  localparam int DEB = 4;
  localparam int PH  = 100;

  logic       clk = 1'b0;
  logic       res_n, ce;
  logic [7:0] pa_raw, pb_raw;
  logic [7:0] pa_in, pb_in;
  logic       in_change;

  int checks = 0;
  int errors = 0;

  riot_port_conditioner #(
    .DEB_W(16), .DEB_CYC(16'd4), .PAUSE_HOLD(16'd100), .SOCD_FILTER(1'b1)
  ) dut (
    .clk(clk), .res_n(res_n), .ce(ce), .pa_raw(pa_raw), .pb_raw(pb_raw),
    .pa_in(pa_in), .pb_in(pb_in), .in_change(in_change)
  );

  always #5 clk = ~clk;

  // Model state: raw history (2-clk sync delay), debounced value with run lengths,
  // pause stretch as "ticks still forced low" plus a wait-for-release flag.
  logic [15:0] h1, h2, m_stable;
  int          m_run [16];
  logic        m_prev, m_wait;
  int          m_hold;
  logic [7:0]  m_pa, m_pb;
  logic        m_chg;

  function automatic logic [3:0] stick(input logic [3:0] s);
    logic [3:0] o;
    o = s;
    if (!s[3] && !s[2]) o[3:2] = 2'b11;
    if (!s[1] && !s[0]) o[1:0] = 2'b11;
    return o;
  endfunction

  task automatic model_update();
    logic [15:0] syn;
    logic [7:0]  fa, fb;
    logic        p;
    if (!res_n) begin
      h1 = '1; h2 = '1; m_stable = '1;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
      m_prev = 1'b1; m_wait = 1'b0; m_hold = 0;
      m_pa = 8'hFF; m_pb = 8'hFF; m_chg = 1'b0;
      return;
    end
    syn = h2;
    h2  = h1;
    h1  = {pb_raw, pa_raw};
    if (!ce) begin
      m_chg = 1'b0;
      return;
    end
    p  = m_stable[11];
    fa = {stick(m_stable[7:4]), stick(m_stable[3:0])};
    fb = m_stable[15:8];
    if (m_hold > 0) fb[3] = 1'b0;
    m_chg = (fa != m_pa) || (fb != m_pb);
    m_pa  = fa;
    m_pb  = fb;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0 && !p) m_wait = 1'b1;
    end else if (m_wait) begin
      if (p) m_wait = 1'b0;
    end else if (!p && m_prev && PH != 0) begin
      m_hold = PH;
    end
    m_prev = p;
    for (int i = 0; i < 16; i++) begin
      if (syn[i] == m_stable[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] >= DEB) begin
          m_stable[i] = syn[i];
          m_run[i]    = 0;
        end
      end
    end
  endtask

  task automatic step(input logic c, input logic [7:0] pa, input logic [7:0] pb, input logic rn);
    ce = c; pa_raw = pa; pb_raw = pb; res_n = rn;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 8'hFF, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 8'hFF, 1'b0);
    repeat (6) step(1'b1, 8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_reset();
    repeat (4) step(1'b1, 8'h00, 8'h00, 1'b0);
    checks++;
    if (pa_in !== 8'hFF) begin errors++; $display("FAIL reset_pa got %h exp ff", pa_in); end
    checks++;
    if (pb_in !== 8'hFF) begin errors++; $display("FAIL reset_pb got %h exp ff", pb_in); end
    checks++;
    if (in_change !== 1'b0) begin errors++; $display("FAIL reset_chg got %b exp 0", in_change); end
  endtask

  task automatic test_debounce();
    int pulses;
    repeat (6) step(1'b1, 8'hFF, 8'hFF, 1'b1);
    repeat (3) step(1'b1, 8'hEF, 8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'hFF, 8'hFF, 1'b1);
      checks++;
      if (pa_in !== 8'hFF || in_change !== 1'b0) begin
        errors++; $display("FAIL glitch step %0d got %h/%b exp ff/0", i, pa_in, in_change);
      end
    end
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 8'hEF, 8'hFF, 1'b1);
      if (in_change === 1'b1) pulses++;
      if (i == 6) begin
        checks++;
        if (pa_in !== 8'hFF) begin errors++; $display("FAIL deb_early got %h exp ff", pa_in); end
      end
      if (i == 7) begin
        checks++;
        if (pa_in !== 8'hEF || in_change !== 1'b1) begin
          errors++; $display("FAIL deb_latency got %h/%b exp ef/1", pa_in, in_change);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL deb_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_socd();
    logic [7:0] pats [3];
    logic [7:0] exps [3];
    pats[0] = 8'h3F; exps[0] = 8'hFF;
    pats[1] = 8'h5F; exps[1] = 8'h5F;
    pats[2] = 8'hFC; exps[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      repeat (12) step(1'b1, pats[k], 8'hFF, 1'b1);
      checks++;
      if (pa_in !== exps[k]) begin
        errors++; $display("FAIL socd raw %h got %h exp %h", pats[k], pa_in, exps[k]);
      end
    end
  endtask

  task automatic test_pause();
    int dut_low, mod_low;
    do_reset();
    dut_low = 0; mod_low = 0;
    for (int i = 1; i <= 210; i++) begin
      step(1'b1, 8'hFF, (i <= 10) ? 8'hF7 : 8'hFF, 1'b1);
      if (pb_in[3] === 1'b0) dut_low++;
      if (m_pb[3] == 1'b0) mod_low++;
      checks++;
      if (pb_in !== m_pb) begin errors++; $display("FAIL tap step %0d got %h exp %h", i, pb_in, m_pb); end
      if (i == 60) begin
        checks++;
        if (pb_in[3] !== 1'b0) begin errors++; $display("FAIL tap_stretch got %b exp 0", pb_in[3]); end
      end
    end
    checks++;
    if (dut_low != mod_low) begin errors++; $display("FAIL tap_len got %0d exp %0d", dut_low, mod_low); end
    checks++;
    if (pb_in !== 8'hFF) begin errors++; $display("FAIL tap_end got %h exp ff", pb_in); end
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 8'hFF, 8'hF7, 1'b1);
      checks++;
      if (pb_in !== m_pb) begin errors++; $display("FAIL long step %0d got %h exp %h", i, pb_in, m_pb); end
    end
    checks++;
    if (pb_in[3] !== 1'b0) begin errors++; $display("FAIL long_hold got %b exp 0", pb_in[3]); end
    repeat (10) step(1'b1, 8'hFF, 8'hFF, 1'b1);
    checks++;
    if (pb_in !== 8'hFF) begin errors++; $display("FAIL long_release got %h exp ff", pb_in); end
  endtask

  task automatic test_ce_gating();
    do_reset();
    repeat (4) step(1'b1, 8'hFE, 8'hFF, 1'b1);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 8'hFE, 8'hFF, 1'b1);
      checks++;
      if (pa_in !== 8'hFF || in_change !== 1'b0) begin
        errors++; $display("FAIL ce_frozen step %0d got %h/%b exp ff/0", i, pa_in, in_change);
      end
    end
    step(1'b1, 8'hFE, 8'hFF, 1'b1);
    step(1'b1, 8'hFE, 8'hFF, 1'b1);
    checks++;
    if (pa_in !== 8'hFF) begin errors++; $display("FAIL ce_resume_early got %h exp ff", pa_in); end
    step(1'b1, 8'hFE, 8'hFF, 1'b1);
    checks++;
    if (pa_in !== 8'hFE || in_change !== 1'b1) begin
      errors++; $display("FAIL ce_resume got %h/%b exp fe/1", pa_in, in_change);
    end
  endtask

  task automatic test_reset_in_hold();
    int bad;
    do_reset();
    repeat (10) step(1'b1, 8'hFF, 8'hF7, 1'b1);
    repeat (30) step(1'b1, 8'hFF, 8'hFF, 1'b1);
    checks++;
    if (pb_in[3] !== 1'b0) begin errors++; $display("FAIL hold_active got %b exp 0", pb_in[3]); end
    step(1'b1, 8'hFF, 8'hFF, 1'b0);
    checks++;
    if (pb_in !== 8'hFF || in_change !== 1'b0) begin
      errors++; $display("FAIL hold_reset got %h/%b exp ff/0", pb_in, in_change);
    end
    bad = 0;
    repeat (40) begin
      step(1'b1, 8'hFF, 8'hFF, 1'b1);
      if (pb_in !== 8'hFF) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_after_reset got %0d low cycles exp 0", bad); end
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic        c, rn;
    r = 16'hFFFF;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) r[$urandom_range(15)] ^= 1'b1;
      c  = ($urandom_range(3) != 0);
      rn = ($urandom_range(499) != 0);
      step(c, r[7:0], r[15:8], rn);
      checks++;
      if (pa_in !== m_pa) begin errors++; $display("FAIL rand_pa step %0d got %h exp %h", i, pa_in, m_pa); end
      checks++;
      if (pb_in !== m_pb) begin errors++; $display("FAIL rand_pb step %0d got %h exp %h", i, pb_in, m_pb); end
      checks++;
      if (in_change !== m_chg) begin errors++; $display("FAIL rand_chg step %0d got %b exp %b", i, in_change, m_chg); end
    end
  endtask

  initial begin
    res_n = 1'b0; ce = 1'b0; pa_raw = 8'hFF; pb_raw = 8'hFF;
    test_reset();
    test_debounce();
    test_socd();
    test_pause();
    test_ce_gating();
    test_reset_in_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
